reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   32-entry integer register file for the RV32I datapath. Supplies the a/b operands
//   (rs1/rs2) to the ALU and accepts the ALU result (or load data) on the single
//   write-back port. Two combinational read ports, one synchronous write port, one
//   debug read port. x0 is hardwired to zero. Optional write-first bypass forwards a
//   same-cycle write to the read ports.
// PARAMETERS
//   XLEN    32  data width of every register and data port
//   NREGS   32  number of architectural registers; fixed at 32 (address width 5)
//   BYPASS  1   1: same-cycle write data is forwarded to matching read ports; 0: no forwarding
// PORTS
//   clk       in   1     rising-edge clock
//   rst_n     in   1     synchronous reset, active low
//   rs1_addr  in   5     read port 1 address (drives ALU operand a)
//   rs2_addr  in   5     read port 2 address (drives ALU operand b)
//   rs1_data  out  XLEN  read port 1 data, combinational
//   rs2_data  out  XLEN  read port 2 data, combinational
//   rd_we     in   1     write enable for the write-back port
//   rd_addr   in   5     write address
//   rd_data   in   XLEN  write data (ALU result / load data)
//   dbg_addr  in   5     debug/testbench read address
//   dbg_data  out  XLEN  debug read data, combinational, never bypassed
// BEHAVIOUR
//   - Storage: regs[1..31], XLEN bits each. No storage exists for x0. Any read of address 0
//     returns 0 on all three read ports, regardless of rd_we, rd_addr or BYPASS.
//   - Reset: on a rising clk edge with rst_n==0, regs[1..31] <= 0 and any write is ignored.
//     Reset has priority over rd_we. A reset asserted mid-stream discards that cycle's write.
//   - Read data is combinational. After the first reset edge, all read ports return 0 until
//     the first write. Before the first reset edge, contents are undefined (X in simulation).
//   - Write: on a rising clk edge with rst_n==1, rd_we==1 and rd_addr!=0:
//     regs[rd_addr] <= rd_data. Writes to x0 are silently dropped.
//     Write latency is 1 cycle: the stored value is visible on all ports the cycle after the edge.
//   - Bypass (BYPASS==1): rsN_data = rd_data when rst_n==1 && rd_we==1 && rd_addr!=0
//     && rd_addr==rsN_addr. Otherwise rsN_data = regs[rsN_addr].
//     Bypass is evaluated independently per port. Both ports may bypass in the same cycle
//     when rs1_addr==rs2_addr==rd_addr.
//     Bypass is suppressed while rst_n==0. dbg_data is never bypassed.
//   - BYPASS==0: read ports return stored contents only. A same-cycle write is seen one
//     cycle later.
//   - No handshake: one write per cycle, accepted unconditionally. Reads have no ordering
//     constraint relative to each other.
//   - Widths: addresses are exactly 5 bits and all 32 values are legal. No sign or zero
//     extension is done here.
// TESTING
//   1. Reset then read: rst_n=0 for 1 edge, then read addresses 0..31 on all ports
//      -> every port returns 32'h0.
//   2. Write/readback: write x5=32'hDEADBEEF and x31=32'h8000_0001, then set rs1=5, rs2=31
//      -> rs1_data=DEADBEEF, rs2_data=80000001, dbg(5)=DEADBEEF.
//   3. x0 immunity: rd_we=1, rd_addr=0, rd_data=32'hFFFF_FFFF, rs1=rs2=0
//      -> rs1/rs2 read 0 in the same cycle and the next cycle (both BYPASS values).
//   4. Bypass: x7 holds 32'h1; same cycle rd_we=1, rd_addr=7, rd_data=32'h2, rs1=rs2=7
//      -> BYPASS=1: both ports=2 and dbg(7)=1; BYPASS=0: both ports=1.
//      Next cycle: all ports=2.
//   5. Reset priority: x3=32'hA5A5A5A5; cycle with rst_n=0, rd_we=1, rd_addr=3, rd_data=32'h5
//      -> no bypass that cycle; after the edge x3=0 (the write is lost).
//   6. ALU loop: x1=7, x2=-3 into ALU ADD, result written to x3 with rs1=3 in the next op
//      -> rs1_data=32'h4 via bypass in the write cycle and from storage afterwards.

Source files
------------

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   32-entry integer register file for the RV32I datapath. The two combinational
//   read ports feed ALU operands a (rs1) and b (rs2). The single synchronous
//   write-back port accepts the ALU result or load data. A third combinational
//   read port is provided for debug and testbench inspection.
//
//   x0 has no storage: every read of address 0 returns zero, and writes to it
//   are dropped. With BYPASS=1, a write that is being committed on the coming
//   edge is forwarded to any read port addressing the same register. This is
//   write-first behaviour, so a dependent instruction in the same cycle sees
//   the new value. The debug port always shows stored contents.
//
// Parameters
//   XLEN    data width of every register and data port
//   NREGS   number of architectural registers (fixed at 32: 5-bit addresses)
//   BYPASS  1: forward same-cycle write data to rs1/rs2; 0: stored data only
//
// Ports
//   clk       in   1     rising-edge clock
//   rst_n     in   1     synchronous reset, active low (clears x1..x31)
//   rs1_addr  in   5     read port 1 address (ALU operand a)
//   rs2_addr  in   5     read port 2 address (ALU operand b)
//   rs1_data  out  XLEN  read port 1 data, combinational
//   rs2_data  out  XLEN  read port 2 data, combinational
//   rd_we     in   1     write-back enable
//   rd_addr   in   5     write-back address
//   rd_data   in   XLEN  write-back data
//   dbg_addr  in   5     debug read address
//   dbg_data  out  XLEN  debug read data, combinational, never bypassed
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            rd_we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // Storage for x1..x(NREGS-1) only. Because x0 has no entry, no write can
  // ever make it non-zero.
  logic [XLEN-1:0] regs [1:NREGS-1];

  // A write commits on the next edge only when reset is released and the
  // target is not x0. The bypass path uses the same qualifier, so a reset
  // cycle or an x0 write is never forwarded.
  logic wr_commit;

  assign wr_commit = rst_n && rd_we && (rd_addr != 5'd0);

  // ---------------------------------------------------------------------------
  // Write port and synchronous reset
  // ---------------------------------------------------------------------------
  // NOTE: every register is cleared by reset because software may rely on
  // zeroed registers after reset. As a result this array maps to flops, not to
  // a RAM macro. A RAM cannot clear all of its words in a single cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        // NOTE: state is updated with non-blocking assignments. Every block
        // then samples the pre-edge value, with no race between processes.
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stored-value lookup for each read port (address 0 reads as zero)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rs1_stored;
  logic [XLEN-1:0] rs2_stored;

  always_comb begin
    // NOTE: defaults are assigned first so that every path drives every
    // output. Otherwise synthesis infers a latch for the x0 case.
    rs1_stored = '0;
    rs2_stored = '0;
    dbg_data   = '0;
    if (rs1_addr != 5'd0) rs1_stored = regs[rs1_addr];
    if (rs2_addr != 5'd0) rs2_stored = regs[rs2_addr];
    if (dbg_addr != 5'd0) dbg_data   = regs[dbg_addr];
  end

  // ---------------------------------------------------------------------------
  // Operand ports, with optional write-first forwarding
  // ---------------------------------------------------------------------------
  generate
    if (BYPASS) begin : g_bypass
      // Each port is compared separately, so both ports may forward in the
      // same cycle. wr_commit already excludes x0, so a port addressing x0
      // keeps reading zero.
      logic rs1_hit;
      logic rs2_hit;

      assign rs1_hit = wr_commit && (rd_addr == rs1_addr);
      assign rs2_hit = wr_commit && (rd_addr == rs2_addr);

      always_comb begin
        rs1_data = rs1_stored;
        rs2_data = rs2_stored;
        if (rs1_hit) rs1_data = rd_data;
        if (rs2_hit) rs2_data = rd_data;
      end
    end else begin : g_no_bypass
      // A same-cycle write becomes visible one cycle later, from storage.
      always_comb begin
        rs1_data = rs1_stored;
        rs2_data = rs2_stored;
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
//   Directed test of reg_file. One instance is built with BYPASS=1 and one with
//   BYPASS=0. Both instances share every input, so each vector checks both
//   forwarding modes. Inputs change 1 time unit after a rising edge and outputs
//   are sampled 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_reg_file;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [4:0]      dbg_addr;

  logic [XLEN-1:0] byp_rs1, byp_rs2, byp_dbg;
  logic [XLEN-1:0] nb_rs1,  nb_rs2,  nb_dbg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file #(.XLEN(XLEN), .NREGS(32), .BYPASS(1'b1)) dut_byp (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (byp_rs1),
    .rs2_data (byp_rs2),
    .rd_we    (rd_we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .dbg_addr (dbg_addr),
    .dbg_data (byp_dbg)
  );

  reg_file #(.XLEN(XLEN), .NREGS(32), .BYPASS(1'b0)) dut_nb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (nb_rs1),
    .rs2_data (nb_rs2),
    .rd_we    (rd_we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .dbg_addr (dbg_addr),
    .dbg_data (nb_dbg)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge, then leave 1 unit before changing inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Commit one write on the next edge, then drop the write enable.
  task automatic write_reg(input logic [4:0] addr, input logic [XLEN-1:0] data);
    rd_we   = 1'b1;
    rd_addr = addr;
    rd_data = data;
    step();
    rd_we   = 1'b0;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2,
                           input logic [4:0] ad);
    rs1_addr = a1;
    rs2_addr = a2;
    dbg_addr = ad;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_we    = 1'b0;
    rd_addr  = 5'd0;
    rd_data  = '0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    dbg_addr = 5'd0;

    // 1. One reset edge, then every address reads zero on every port.
    step();
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      set_reads(5'(a), 5'(31 - a), 5'(a));
      check($sformatf("rst byp rs1 x%0d", a), byp_rs1, 32'h0);
      check($sformatf("rst byp rs2 x%0d", 31 - a), byp_rs2, 32'h0);
      check($sformatf("rst byp dbg x%0d", a), byp_dbg, 32'h0);
      check($sformatf("rst nb rs1 x%0d", a), nb_rs1, 32'h0);
      check($sformatf("rst nb rs2 x%0d", 31 - a), nb_rs2, 32'h0);
      check($sformatf("rst nb dbg x%0d", a), nb_dbg, 32'h0);
    end

    // 2. Write and read back, including the top register x31.
    write_reg(5'd5, 32'hDEAD_BEEF);
    write_reg(5'd31, 32'h8000_0001);
    set_reads(5'd5, 5'd31, 5'd5);
    check("wr byp rs1 x5", byp_rs1, 32'hDEAD_BEEF);
    check("wr byp rs2 x31", byp_rs2, 32'h8000_0001);
    check("wr byp dbg x5", byp_dbg, 32'hDEAD_BEEF);
    check("wr nb rs1 x5", nb_rs1, 32'hDEAD_BEEF);
    check("wr nb rs2 x31", nb_rs2, 32'h8000_0001);
    check("wr nb dbg x5", nb_dbg, 32'hDEAD_BEEF);

    // A cycle with rd_we low must not write, even with a live address and data.
    rd_we = 1'b0; rd_addr = 5'd9; rd_data = 32'h1234_5678;
    step();
    set_reads(5'd9, 5'd9, 5'd9);
    check("no-we byp rs1 x9", byp_rs1, 32'h0);
    check("no-we nb dbg x9", nb_dbg, 32'h0);

    // 3. x0 immunity: same cycle and the next, both bypass modes.
    rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF;
    set_reads(5'd0, 5'd0, 5'd0);
    check("x0 same byp rs1", byp_rs1, 32'h0);
    check("x0 same byp rs2", byp_rs2, 32'h0);
    check("x0 same nb rs1", nb_rs1, 32'h0);
    check("x0 same nb rs2", nb_rs2, 32'h0);
    step();
    rd_we = 1'b0;
    #1;
    check("x0 next byp rs1", byp_rs1, 32'h0);
    check("x0 next byp rs2", byp_rs2, 32'h0);
    check("x0 next byp dbg", byp_dbg, 32'h0);
    check("x0 next nb rs1", nb_rs1, 32'h0);
    check("x0 next nb rs2", nb_rs2, 32'h0);

    // 4. Bypass: x7 holds 1, then 2 is written while both ports read x7.
    write_reg(5'd7, 32'h1);
    rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'h2;
    set_reads(5'd7, 5'd7, 5'd7);
    check("byp same byp rs1", byp_rs1, 32'h2);
    check("byp same byp rs2", byp_rs2, 32'h2);
    check("byp same byp dbg", byp_dbg, 32'h1);
    check("byp same nb rs1", nb_rs1, 32'h1);
    check("byp same nb rs2", nb_rs2, 32'h1);
    check("byp same nb dbg", nb_dbg, 32'h1);
    // Forwarding is per port: only the port addressing x7 forwards.
    set_reads(5'd7, 5'd5, 5'd7);
    check("byp split byp rs1", byp_rs1, 32'h2);
    check("byp split byp rs2", byp_rs2, 32'hDEAD_BEEF);
    set_reads(5'd5, 5'd7, 5'd7);
    check("byp split2 byp rs1", byp_rs1, 32'hDEAD_BEEF);
    check("byp split2 byp rs2", byp_rs2, 32'h2);
    set_reads(5'd7, 5'd7, 5'd7);
    step();
    rd_we = 1'b0;
    #1;
    check("byp next byp rs1", byp_rs1, 32'h2);
    check("byp next byp rs2", byp_rs2, 32'h2);
    check("byp next byp dbg", byp_dbg, 32'h2);
    check("byp next nb rs1", nb_rs1, 32'h2);
    check("byp next nb rs2", nb_rs2, 32'h2);
    check("byp next nb dbg", nb_dbg, 32'h2);

    // 5. Reset priority: the write in the reset cycle is neither forwarded
    //    nor stored.
    write_reg(5'd3, 32'hA5A5_A5A5);
    rst_n = 1'b0; rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'h5;
    set_reads(5'd3, 5'd3, 5'd3);
    check("rstpri same byp rs1", byp_rs1, 32'hA5A5_A5A5);
    check("rstpri same byp rs2", byp_rs2, 32'hA5A5_A5A5);
    check("rstpri same nb rs1", nb_rs1, 32'hA5A5_A5A5);
    step();
    rst_n = 1'b1; rd_we = 1'b0;
    #1;
    check("rstpri after byp rs1", byp_rs1, 32'h0);
    check("rstpri after nb dbg", nb_dbg, 32'h0);
    set_reads(5'd5, 5'd31, 5'd7);
    check("rstpri after byp x5", byp_rs1, 32'h0);
    check("rstpri after byp x31", byp_rs2, 32'h0);
    check("rstpri after byp x7", byp_dbg, 32'h0);

    // 6. ALU loop: x1=7, x2=-3, ADD result (7 + -3 = 4) written to x3 while
    //    the next operation reads x3 on rs1.
    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'hFFFF_FFFD);
    set_reads(5'd1, 5'd2, 5'd0);
    check("alu byp opa", byp_rs1, 32'd7);
    check("alu byp opb", byp_rs2, 32'hFFFF_FFFD);
    rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'h4;
    set_reads(5'd3, 5'd2, 5'd3);
    check("alu wb byp rs1", byp_rs1, 32'h4);
    check("alu wb byp dbg", byp_dbg, 32'h0);
    check("alu wb nb rs1", nb_rs1, 32'h0);
    step();
    rd_we = 1'b0;
    #1;
    check("alu next byp rs1", byp_rs1, 32'h4);
    check("alu next nb rs1", nb_rs1, 32'h4);
    check("alu next byp dbg", byp_dbg, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
